fa_case: RTL and testbench

FA_CASE -- requirements
Module: fa_case

---
 rtl/fa_pkg.sv | 15 +
 rtl/fa_cell.sv | 28 ++
 rtl/fa_case.sv | 98 +++++++++
 tb/tb_fa_case.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fa_pkg.sv
// Shared constants for the ripple-carry adder: the one-bit {co,s} truth table
// and the supported operand width limit.
package fa_pkg;

   localparam int WIDTH_MAX = 64;

   // Entry i (i = {ci,a,b}) lives in bits [2*i+1 : 2*i] and holds {co,s}.
   localparam logic [15:0] FA_TRUTH = {2'b11, 2'b10, 2'b10, 2'b01,
                                       2'b10, 2'b01, 2'b01, 2'b00};

   function automatic logic [1:0] fa_entry(input logic [2:0] idx);
      return FA_TRUTH[{idx, 1'b0} +: 2];
   endfunction

endpackage

// File: rtl/fa_cell.sv
// One-bit full adder cell, written as an exhaustive case over {ci,a,b}
// looked up in the shared truth table.
module fa_cell
   import fa_pkg::*;
(
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   always_comb begin
      {co, s} = 2'b00;
      case ({ci, a, b})
         3'b000:  {co, s} = fa_entry(3'd0);
         3'b001:  {co, s} = fa_entry(3'd1);
         3'b010:  {co, s} = fa_entry(3'd2);
         3'b011:  {co, s} = fa_entry(3'd3);
         3'b100:  {co, s} = fa_entry(3'd4);
         3'b101:  {co, s} = fa_entry(3'd5);
         3'b110:  {co, s} = fa_entry(3'd6);
         3'b111:  {co, s} = fa_entry(3'd7);
         default: {co, s} = 2'b00;
      endcase
   end

endmodule

// File: rtl/fa_case.sv
// Registered WIDTH-bit ripple-carry adder built from fa_cell instances.
// Define FA_CROSSCHECK_EN to add dataflow and behavioural reference checks driving chk_err.
module fa_case
   import fa_pkg::*;
#(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             ci,
   output logic             out_valid,
   output logic [WIDTH-1:0] s,
   output logic             co,
   output logic             chk_err
);

   if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("fa_case: WIDTH out of range");
   end

   logic [WIDTH:0]   carry;
   logic [WIDTH-1:0] sum_c;

   assign carry[0] = ci;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
      fa_cell u_cell (
         .a  (a[gi]),
         .b  (b[gi]),
         .ci (carry[gi]),
         .s  (sum_c[gi]),
         .co (carry[gi+1])
      );
   end

   logic [WIDTH-1:0] s_d, s_q;
   logic             co_d, co_q;
   logic             out_valid_q;

   always_comb begin
      s_d  = s_q;
      co_d = co_q;
      if (in_valid) begin
         s_d  = sum_c;
         co_d = carry[WIDTH];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s_q         <= '0;
         co_q        <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         s_q         <= s_d;
         co_q        <= co_d;
         out_valid_q <= in_valid;
      end
   end

   assign s         = s_q;
   assign co        = co_q;
   assign out_valid = out_valid_q;

`ifdef FA_CROSSCHECK_EN
   logic [WIDTH-1:0] ref_s;
   logic [WIDTH:0]   ref_c;
   logic [WIDTH:0]   beh_sum;
   logic             mismatch;
   logic             chk_err_d, chk_err_q;

   assign ref_c[0] = ci;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_ref
      assign ref_s[gi]   = a[gi] ^ b[gi] ^ ref_c[gi];
      assign ref_c[gi+1] = (a[gi] & b[gi]) | (ref_c[gi] & (a[gi] ^ b[gi]));
   end

   assign beh_sum   = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, ci};
   assign mismatch  = ({carry[WIDTH], sum_c} != {ref_c[WIDTH], ref_s}) ||
                      ({carry[WIDTH], sum_c} != beh_sum);
   // Flag lands alongside out_valid for the offending operand set, then sticks.
   assign chk_err_d = chk_err_q | (in_valid & mismatch);

   always_ff @(posedge clk) begin
      if (rst) chk_err_q <= 1'b0;
      else     chk_err_q <= chk_err_d;
   end

   assign chk_err = chk_err_q;
`else
   assign chk_err = 1'b0;
`endif

endmodule

// File: tb/tb_fa_case.sv
// Scoreboard bench: one stimulus stream drives a WIDTH=1 and a WIDTH=8 adder;
// expected results are queued by the driver and retired by a negedge monitor.
module tb_fa_case;

   typedef struct {
      int       due;
      bit       is_rst;
      bit [7:0] s8;
      bit       co8;
      bit       s1;
      bit       co1;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       ci = 1'b0;

   logic       ov1, s1, co1, err1;
   logic       ov8, co8, err8;
   logic [7:0] s8;

   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   bit   armed = 1'b0;
   exp_t q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fa_case #(.WIDTH(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a[0]), .b(b[0]), .ci(ci),
      .out_valid(ov1), .s(s1), .co(co1), .chk_err(err1)
   );

   fa_case #(.WIDTH(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .ci(ci),
      .out_valid(ov8), .s(s8), .co(co8), .chk_err(err8)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask

   // Drive one cycle of inputs and queue what should appear one cycle later.
   task automatic drive(input bit r, input bit v, input bit [7:0] av, input bit [7:0] bv, input bit cv);
      exp_t e;
      int   sum8, sum1;
      @(posedge clk);
      #1;
      rst = r; in_valid = v; a = av; b = bv; ci = cv;
      sum8 = int'(av) + int'(bv) + int'(cv);
      sum1 = int'(av[0]) + int'(bv[0]) + int'(cv);
      e.due = cyc + 1;
      e.is_rst = r;
      e.s8 = sum8[7:0];
      e.co8 = sum8[8];
      e.s1 = sum1[0];
      e.co1 = sum1[1];
      if (r || v) q.push_back(e);
      $display("[TB] cyc %0d rst=%0b vld=%0b a=%02h b=%02h ci=%0b", cyc, r, v, av, bv, cv);
   endtask

   bit [7:0] hold_s8 = '0;
   bit       hold_co8 = 1'b0, hold_s1 = 1'b0, hold_co1 = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      bit   have, exp_v;
      have = 1'b0;
      exp_v = 1'b0;
      if (q.size() != 0 && q[0].due < cyc) begin
         chk("stale_expectation", 64'(q[0].due), 64'(cyc));
         void'(q.pop_front());
      end
      if (q.size() != 0 && q[0].due == cyc) begin
         e = q.pop_front();
         have = 1'b1;
      end
      if (have && e.is_rst) begin
         hold_s8 = '0; hold_co8 = 1'b0; hold_s1 = 1'b0; hold_co1 = 1'b0;
         armed = 1'b1;
      end else if (have) begin
         exp_v = 1'b1;
         hold_s8 = e.s8; hold_co8 = e.co8; hold_s1 = e.s1; hold_co1 = e.co1;
      end
      if (armed) begin
         chk("out_valid_w8", 64'(ov8), 64'(exp_v));
         chk("s_w8", 64'(s8), 64'(hold_s8));
         chk("co_w8", 64'(co8), 64'(hold_co8));
         chk("out_valid_w1", 64'(ov1), 64'(exp_v));
         chk("s_w1", 64'(s1), 64'(hold_s1));
         chk("co_w1", 64'(co1), 64'(hold_co1));
         chk("chk_err", 64'({err8, err1}), 64'(0));
      end
   end

   initial begin
      // reset
      drive(1, 0, 8'h00, 8'h00, 0);
      drive(1, 0, 8'h00, 8'h00, 0);
      // exhaustive single-bit sweep of {ci,a,b}, back-to-back
      for (int i = 0; i < 8; i++) begin
         bit [2:0] v;
         v = 3'(i);
         drive(0, 1, {7'($urandom), v[1]}, {7'($urandom), v[0]}, v[2]);
      end
      // carry-propagate and full-overflow corners
      drive(0, 1, 8'hFF, 8'h01, 0);
      drive(0, 1, 8'hFF, 8'hFF, 1);
      // single pulse then idle: values must hold
      drive(0, 1, 8'h5A, 8'h33, 1);
      drive(0, 0, 8'h12, 8'h34, 0);
      drive(0, 0, 8'hFF, 8'hFF, 1);
      drive(0, 0, 8'h00, 8'h00, 0);
      // reset collides with valid operands: they are discarded
      drive(0, 1, 8'hC3, 8'h7E, 1);
      drive(1, 1, 8'h01, 8'h01, 0);
      drive(0, 0, 8'h01, 8'h01, 0);
      // random traffic with gaps and occasional resets
      for (int i = 0; i < 1000; i++) begin
         drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) != 0),
               8'($urandom), 8'($urandom), 1'($urandom));
      end
      drive(0, 0, 8'h00, 8'h00, 0);
      drive(0, 0, 8'h00, 8'h00, 0);
      drive(0, 0, 8'h00, 8'h00, 0);
      @(negedge clk);
      chk("scoreboard_drained", 64'(q.size()), 64'(0));
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
